icache_axi_refill: RTL and testbench
====================================

// Module: icache_axi_refill
// PURPOSE
//  AXI4 read-burst master refilling one I-cache line per miss. Takes a miss request from the I-cache
//  controller, issues one INCR burst of N_WORD beats on AR, assembles R beats into a line buffer and
//  returns the whole line with an error flag. Sits between I-cache controller and the AXI interconnect.
//  Successor to the single-beat I-cache AXI port: adds bursts, RLAST/RRESP checking and flush-discard.
// PARAMETERS
//  ADDR_W       32       address width
//  DATA_W       32       AXI RDATA width; one beat = one cache word (32/64)
//  N_WORD       8        words per line; power of 2, 2..256
//  ARCACHE_VAL  4'b0110  ARCACHE driven on every burst
//  ARPROT_VAL   3'b100   ARPROT: unprivileged, secure, instruction access
// PORTS
//  AXI_CLK      in   1               clock, rising edge
//  AXI_RESETn   in   1               reset, asynchronous, active-low
//  miss_req     in   1               level; held by controller until refill_valid
//  miss_addr    in   ADDR_W          miss address; sampled in IDLE when miss_req=1
//  flush        in   1               discard any refill in flight
//  busy         out  1               FSM not in IDLE
//  refill_valid out  1               one-cycle pulse: refill_line valid
//  refill_line  out  DATA_W*N_WORD   word i at bits [i*DATA_W +: DATA_W]
//  refill_err   out  1               qualifies refill_valid: SLVERR/DECERR or RLAST protocol error
//  AXI_ARVALID/ARREADY out/in 1      AR handshake
//  AXI_ARADDR   out  ADDR_W          line-aligned address
//  AXI_ARLEN    out  8               N_WORD-1
//  AXI_ARSIZE   out  3               log2(DATA_W/8)
//  AXI_ARBURST  out  2               2'b01 INCR
//  AXI_ARPROT/ARCACHE out 3/4        ARPROT_VAL / ARCACHE_VAL
//  AXI_RVALID/RREADY in/out 1        R handshake
//  AXI_RDATA    in   DATA_W          beat data
//  AXI_RRESP    in   2               beat response
//  AXI_RLAST    in   1               last beat marker
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except ARLEN/ARSIZE/ARBURST/ARPROT/ARCACHE (constants); beat_cnt=0;
//   line buffer cleared. Reset mid-burst abandons the burst; no refill_valid afterwards.
//  FSM IDLE->ADDR->DATA->RESP->IDLE.
//  IDLE: miss_req && !flush -> latch ARADDR = miss_addr with low log2(N_WORD*DATA_W/8) bits zeroed,
//   clear err/discard flags, go ADDR. ARVALID=1 from next cycle.
//  ADDR: ARVALID held, ARADDR stable until ARVALID&&ARREADY; then ARVALID=0, go DATA, beat_cnt=0.
//  DATA: RREADY=1. Each RVALID&&RREADY: buffer[beat_cnt]<=RDATA; err|=RRESP[1]; beat_cnt++ (wraps 0).
//   Beat with beat_cnt==N_WORD-1: err|=!RLAST; go RESP. RLAST on earlier beat: err=1, go RESP
//   (remaining words keep stale content). RREADY deasserted outside DATA.
//  RESP (1 cycle): refill_valid=1, refill_err=err unless discard set; then IDLE. RESP->IDLE
//   ignores miss_req that cycle (controller drops it on refill_valid); next miss earliest the following cycle.
//  flush: IDLE -> request ignored that cycle. ADDR/DATA -> set discard; burst still completes on AXI
//   (no AXI abort), refill_valid suppressed in RESP. flush in RESP suppresses that pulse.
//  Latency: miss_req @T0 -> ARVALID @T1; ARREADY=1 and back-to-back beats -> refill_valid @T2+N_WORD.
//  miss_addr/miss_req changes outside IDLE are ignored. Single outstanding burst; ARID not used.
// STRUCTURE
//  Package icache_axi_pkg: state enum (IDLE/ADDR/DATA/RESP), AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00,
//   AXI_RESP_SLVERR=2'b10, AXI_RESP_DECERR=2'b11, function clog2.
//  Sub-module icache_refill_linebuf: N_WORD x DATA_W register file, write-enable + beat index,
//   parallel line output, async clear. FSM, beat counter, AXI drive stay in the top.
// TESTING
//  1 N_WORD=8, miss_addr=0x0000_1234, ARREADY=1, 8 beats RDATA=0xA0..0xA7, RLAST on 8th, OKAY ->
//    ARADDR=0x0000_1220, ARLEN=7, ARSIZE=2, refill_valid @T10, line word i=0xA0+i, err=0.
//  2 ARREADY low 5 cycles, random RVALID gaps -> ARVALID/ARADDR stable until accepted; line correct.
//  3 RRESP=2'b10 on beat 3 only -> full burst consumed, refill_valid=1 with refill_err=1.
//  4 RLAST on beat 5 of 8 -> RESP next cycle, refill_err=1; RLAST missing on beat 8 -> refill_err=1.
//  5 flush during DATA beat 2 -> all 8 beats accepted, no refill_valid, busy=0 after burst, next miss OK.
//  6 AXI_RESETn low during DATA beat 4 -> outputs at reset values asynchronously, no refill_valid.

Source files
------------

// File: rtl/icache_axi_pkg.sv
// ----------------------------------------------------------------------------
// icache_axi_pkg
// Shared types and constants for the I-cache AXI4 refill path.
//   state_t  : refill FSM states (IDLE -> ADDR -> DATA -> RESP -> IDLE)
//   AXI_*    : AXI4 burst-type and response encodings
//   clog2    : ceiling log2, usable in parameter/localparam expressions
// ----------------------------------------------------------------------------
package icache_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/icache_refill_linebuf.sv
// ----------------------------------------------------------------------------
// icache_refill_linebuf
// N_WORD x DATA_W line buffer filled one beat at a time, read as a whole line.
// Ports:
//   AXI_CLK     in   clock, rising edge
//   AXI_RESETn  in   asynchronous active-low clear of every word
//   wr_en       in   write wr_data into word wr_idx this cycle
//   wr_idx      in   IDX_W-bit word index
//   wr_data     in   DATA_W-bit beat data
//   line        out  word i at bits [i*DATA_W +: DATA_W]
// ----------------------------------------------------------------------------
module icache_refill_linebuf
    import icache_axi_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_WORD = 8,
    parameter int IDX_W  = clog2(N_WORD)
) (
    input  logic                     AXI_CLK,
    input  logic                     AXI_RESETn,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [N_WORD*DATA_W-1:0] line
);

    logic [N_WORD*DATA_W-1:0] line_q;

    // NOTE: this storage is reset on purpose: a burst cut short by an early
    // RLAST leaves the untouched words visible, and they must read as zero
    // rather than X after reset. Plain storage arrays normally get no reset.
    always_ff @(posedge AXI_CLK or negedge AXI_RESETn) begin
        if (!AXI_RESETn) begin
            line_q <= '0;
        end else if (wr_en) begin
            line_q[wr_idx*DATA_W +: DATA_W] <= wr_data;
        end
    end

    assign line = line_q;

endmodule

// File: rtl/icache_axi_refill.sv
// ----------------------------------------------------------------------------
// icache_axi_refill
// AXI4 read-burst master refilling one I-cache line per miss. A miss issues
// one INCR burst of N_WORD beats; beats are assembled into a line buffer and
// the full line is returned with an error flag (bad RRESP or RLAST misplaced).
// A flush while a burst is in flight lets the burst drain on AXI but drops the
// result.
// Ports:
//   AXI_CLK, AXI_RESETn       clock / async active-low reset
//   miss_req, miss_addr       miss request (level) and address, sampled in IDLE
//   flush                     discard refill in flight / suppress RESP pulse
//   busy                      FSM not idle
//   refill_valid              one-cycle pulse, refill_line valid
//   refill_line               N_WORD words, word i at [i*DATA_W +: DATA_W]
//   refill_err                qualifies refill_valid
//   AXI_AR*                   read address channel (constants on LEN/SIZE/...)
//   AXI_R*                    read data channel
// ----------------------------------------------------------------------------
module icache_axi_refill
    import icache_axi_pkg::*;
#(
    parameter int         ADDR_W      = 32,
    parameter int         DATA_W      = 32,
    parameter int         N_WORD      = 8,
    parameter logic [3:0] ARCACHE_VAL = 4'b0110,
    parameter logic [2:0] ARPROT_VAL  = 3'b100
) (
    input  logic                     AXI_CLK,
    input  logic                     AXI_RESETn,
    input  logic                     miss_req,
    input  logic [ADDR_W-1:0]        miss_addr,
    input  logic                     flush,
    output logic                     busy,
    output logic                     refill_valid,
    output logic [N_WORD*DATA_W-1:0] refill_line,
    output logic                     refill_err,
    output logic                     AXI_ARVALID,
    input  logic                     AXI_ARREADY,
    output logic [ADDR_W-1:0]        AXI_ARADDR,
    output logic [7:0]               AXI_ARLEN,
    output logic [2:0]               AXI_ARSIZE,
    output logic [1:0]               AXI_ARBURST,
    output logic [2:0]               AXI_ARPROT,
    output logic [3:0]               AXI_ARCACHE,
    input  logic                     AXI_RVALID,
    output logic                     AXI_RREADY,
    input  logic [DATA_W-1:0]        AXI_RDATA,
    input  logic [1:0]               AXI_RRESP,
    input  logic                     AXI_RLAST
);

    localparam int               IDX_W    = clog2(N_WORD);
    localparam int               OFF_W    = clog2(N_WORD * DATA_W / 8);
    localparam int               SIZE_VAL = clog2(DATA_W / 8);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORD - 1);

    state_t              state;
    logic [IDX_W-1:0]    beat_cnt;
    logic [ADDR_W-1:0]   araddr_q;
    logic                arvalid_q;
    logic                rready_q;
    logic                err_q;
    logic                discard_q;
    logic                refill_valid_q;
    logic                refill_err_q;

    logic                beat_fire;
    logic                resp_err;
    logic                burst_end;
    logic                end_err;

    // NOTE: every signal assigned here gets a value on every path, so this
    // block stays purely combinational and cannot infer a latch.
    always_comb begin
        beat_fire = rready_q && AXI_RVALID;
        resp_err  = (AXI_RRESP == AXI_RESP_SLVERR) || (AXI_RRESP == AXI_RESP_DECERR);
        burst_end = (beat_cnt == LAST_IDX) || AXI_RLAST;
        // On the final beat the only error source beyond RRESP is a missing
        // RLAST; an RLAST before the final beat is always an error.
        end_err   = err_q || resp_err || (beat_cnt != LAST_IDX) || !AXI_RLAST;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge AXI_CLK or negedge AXI_RESETn) begin
        if (!AXI_RESETn) begin
            state          <= ST_IDLE;
            beat_cnt       <= '0;
            araddr_q       <= '0;
            arvalid_q      <= 1'b0;
            rready_q       <= 1'b0;
            err_q          <= 1'b0;
            discard_q      <= 1'b0;
            refill_valid_q <= 1'b0;
            refill_err_q   <= 1'b0;
        end else begin
            refill_valid_q <= 1'b0;
            refill_err_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (miss_req && !flush) begin
                        araddr_q  <= {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        arvalid_q <= 1'b1;
                        err_q     <= 1'b0;
                        discard_q <= 1'b0;
                        state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (flush) discard_q <= 1'b1;
                    if (AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        beat_cnt  <= '0;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (flush) discard_q <= 1'b1;
                    if (beat_fire) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (burst_end) begin
                            err_q          <= end_err;
                            rready_q       <= 1'b0;
                            refill_valid_q <= !(discard_q || flush);
                            refill_err_q   <= end_err;
                            state          <= ST_RESP;
                        end else begin
                            err_q <= err_q || resp_err;
                        end
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    icache_refill_linebuf #(
        .DATA_W (DATA_W),
        .N_WORD (N_WORD),
        .IDX_W  (IDX_W)
    ) u_linebuf (
        .AXI_CLK    (AXI_CLK),
        .AXI_RESETn (AXI_RESETn),
        .wr_en      (beat_fire),
        .wr_idx     (beat_cnt),
        .wr_data    (AXI_RDATA),
        .line       (refill_line)
    );

    // A flush arriving in the RESP cycle itself still kills the pulse.
    assign refill_valid = refill_valid_q && !flush;
    assign refill_err   = refill_err_q && refill_valid;
    assign busy         = (state != ST_IDLE);

    assign AXI_ARVALID  = arvalid_q;
    assign AXI_ARADDR   = araddr_q;
    assign AXI_ARLEN    = 8'(N_WORD - 1);
    assign AXI_ARSIZE   = 3'(SIZE_VAL);
    assign AXI_ARBURST  = AXI_BURST_INCR;
    assign AXI_ARPROT   = ARPROT_VAL;
    assign AXI_ARCACHE  = ARCACHE_VAL;
    assign AXI_RREADY   = rready_q;

endmodule

// File: tb/tb_icache_axi_refill.sv
// ----------------------------------------------------------------------------
// tb_icache_axi_refill
// Self-checking bench for icache_axi_refill (N_WORD=8, DATA_W=32). The bench
// plays both the I-cache controller and the AXI slave; a line-sized array
// holds the expected buffer contents and the error flag is derived from the
// RRESP/RLAST rules per beat.
// ----------------------------------------------------------------------------
module tb_icache_axi_refill;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int N_WORD = 8;

    logic                     AXI_CLK;
    logic                     AXI_RESETn;
    logic                     miss_req;
    logic [ADDR_W-1:0]        miss_addr;
    logic                     flush;
    logic                     busy;
    logic                     refill_valid;
    logic [N_WORD*DATA_W-1:0] refill_line;
    logic                     refill_err;
    logic                     AXI_ARVALID;
    logic                     AXI_ARREADY;
    logic [ADDR_W-1:0]        AXI_ARADDR;
    logic [7:0]               AXI_ARLEN;
    logic [2:0]               AXI_ARSIZE;
    logic [1:0]               AXI_ARBURST;
    logic [2:0]               AXI_ARPROT;
    logic [3:0]               AXI_ARCACHE;
    logic                     AXI_RVALID;
    logic                     AXI_RREADY;
    logic [DATA_W-1:0]        AXI_RDATA;
    logic [1:0]               AXI_RRESP;
    logic                     AXI_RLAST;

    int total = 0;
    int bad   = 0;

    // Expected contents of the line buffer (persists across refills).
    logic [DATA_W-1:0] exp_line [N_WORD];

    icache_axi_refill #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .N_WORD (N_WORD)
    ) dut (
        .AXI_CLK      (AXI_CLK),
        .AXI_RESETn   (AXI_RESETn),
        .miss_req     (miss_req),
        .miss_addr    (miss_addr),
        .flush        (flush),
        .busy         (busy),
        .refill_valid (refill_valid),
        .refill_line  (refill_line),
        .refill_err   (refill_err),
        .AXI_ARVALID  (AXI_ARVALID),
        .AXI_ARREADY  (AXI_ARREADY),
        .AXI_ARADDR   (AXI_ARADDR),
        .AXI_ARLEN    (AXI_ARLEN),
        .AXI_ARSIZE   (AXI_ARSIZE),
        .AXI_ARBURST  (AXI_ARBURST),
        .AXI_ARPROT   (AXI_ARPROT),
        .AXI_ARCACHE  (AXI_ARCACHE),
        .AXI_RVALID   (AXI_RVALID),
        .AXI_RREADY   (AXI_RREADY),
        .AXI_RDATA    (AXI_RDATA),
        .AXI_RRESP    (AXI_RRESP),
        .AXI_RLAST    (AXI_RLAST)
    );

    initial AXI_CLK = 1'b0;
    always #5 AXI_CLK = ~AXI_CLK;

    function automatic logic [N_WORD*DATA_W-1:0] pack_model();
        logic [N_WORD*DATA_W-1:0] v;
        for (int i = 0; i < N_WORD; i++) v[i*DATA_W +: DATA_W] = exp_line[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N_WORD; i++) exp_line[i] = '0;
    endtask

    task automatic idle_inputs();
        miss_req    = 1'b0;
        miss_addr   = '0;
        flush       = 1'b0;
        AXI_ARREADY = 1'b0;
        AXI_RVALID  = 1'b0;
        AXI_RDATA   = '0;
        AXI_RRESP   = 2'b00;
        AXI_RLAST   = 1'b0;
    endtask

    // One complete refill transaction.
    //   rlast_idx  : beat carrying RLAST (N_WORD-1 normal, smaller = early, -1 = never)
    //   bad_beat   : beat answered with SLVERR/DECERR (-1 none)
    //   flush_beat : beat during which flush is raised; N_WORD-or-burst-length = in RESP; -1 none
    task automatic run_refill(input string name, input logic [ADDR_W-1:0] addr,
                              input int ar_wait, input int gap_max, input int bad_beat,
                              input int rlast_idx, input int flush_beat, input bit fixed_data);
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        bit                exp_err;
        bit                flushed;
        int                n;
        int                cycles;
        int                spurious;
        int                unstable;
        int                gaps;

        exp_addr = addr & ~ADDR_W'(N_WORD * DATA_W / 8 - 1);
        exp_err  = 1'b0;
        flushed  = 1'b0;
        cycles   = 0;
        spurious = 0;
        unstable = 0;
        n        = (rlast_idx >= 0 && rlast_idx < N_WORD - 1) ? rlast_idx + 1 : N_WORD;

        @(negedge AXI_CLK);
        miss_req  = 1'b1;
        miss_addr = addr;
        @(negedge AXI_CLK);
        cycles++;
        total++;
        if (AXI_ARVALID !== 1'b1 || AXI_ARADDR !== exp_addr || busy !== 1'b1) begin
            $display("FAIL %s ar_issue: arvalid=%b araddr=%h busy=%b, expected 1 %h 1",
                     name, AXI_ARVALID, AXI_ARADDR, busy, exp_addr);
            bad++;
        end

        for (int w = 0; w < ar_wait; w++) begin
            miss_addr   = $urandom;
            AXI_ARREADY = 1'b0;
            @(negedge AXI_CLK);
            cycles++;
            if (AXI_ARVALID !== 1'b1 || AXI_ARADDR !== exp_addr) unstable++;
        end
        if (ar_wait > 0) begin
            total++;
            if (unstable != 0) begin
                $display("FAIL %s ar_stable: %0d unstable cycles, expected 0", name, unstable);
                bad++;
            end
        end

        AXI_ARREADY = 1'b1;
        @(negedge AXI_CLK);
        cycles++;
        AXI_ARREADY = 1'b0;
        total++;
        if (AXI_ARVALID !== 1'b0 || AXI_RREADY !== 1'b1) begin
            $display("FAIL %s ar_accept: arvalid=%b rready=%b, expected 0 1",
                     name, AXI_ARVALID, AXI_RREADY);
            bad++;
        end

        for (int i = 0; i < n; i++) begin
            gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (gaps) begin
                AXI_RVALID = 1'b0;
                @(negedge AXI_CLK);
                cycles++;
                if (refill_valid !== 1'b0) spurious++;
            end
            data = fixed_data ? DATA_W'(32'hA0 + i) : DATA_W'($urandom);
            if (i == bad_beat) resp = ($urandom_range(1, 0) != 0) ? 2'b10 : 2'b11;
            else               resp = ($urandom_range(1, 0) != 0) ? 2'b00 : 2'b01;
            if (fixed_data && i != bad_beat) resp = 2'b00;
            last = (i == rlast_idx);
            if (i == flush_beat) begin
                flush    = 1'b1;
                flushed  = 1'b1;
                miss_req = 1'b0;
            end
            AXI_RVALID = 1'b1;
            AXI_RDATA  = data;
            AXI_RRESP  = resp;
            AXI_RLAST  = last;
            exp_line[i] = data;
            if (resp[1]) exp_err = 1'b1;
            if (i == N_WORD - 1 && !last) exp_err = 1'b1;
            if (last && i < N_WORD - 1) exp_err = 1'b1;
            @(negedge AXI_CLK);
            cycles++;
            flush = 1'b0;
            if (i < n - 1 && refill_valid !== 1'b0) spurious++;
        end
        AXI_RVALID = 1'b0;
        AXI_RLAST  = 1'b0;

        if (flush_beat == n) begin
            flush    = 1'b1;
            flushed  = 1'b1;
            miss_req = 1'b0;
            #1;
        end

        total++;
        if (spurious != 0) begin
            $display("FAIL %s early_pulse: %0d early refill_valid cycles, expected 0", name, spurious);
            bad++;
        end
        total++;
        if (refill_valid !== !flushed) begin
            $display("FAIL %s refill_valid: got %b expected %b", name, refill_valid, !flushed);
            bad++;
        end
        if (!flushed) begin
            total++;
            if (refill_err !== exp_err) begin
                $display("FAIL %s refill_err: got %b expected %b", name, refill_err, exp_err);
                bad++;
            end
            total++;
            if (refill_line !== pack_model()) begin
                $display("FAIL %s refill_line: got %h expected %h", name, refill_line, pack_model());
                bad++;
            end
            if (ar_wait == 0 && gap_max == 0) begin
                total++;
                if (cycles != 2 + n) begin
                    $display("FAIL %s latency: refill_valid at T%0d expected T%0d", name, cycles, 2 + n);
                    bad++;
                end
            end
        end

        miss_req = 1'b0;
        @(negedge AXI_CLK);
        flush = 1'b0;
        total++;
        if (busy !== 1'b0 || refill_valid !== 1'b0 || AXI_RREADY !== 1'b0) begin
            $display("FAIL %s back_to_idle: busy=%b refill_valid=%b rready=%b expected 0 0 0",
                     name, busy, refill_valid, AXI_RREADY);
            bad++;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        AXI_RESETn = 1'b0;
        model_clear();
        repeat (3) @(negedge AXI_CLK);
        total++;
        if (busy !== 1'b0 || refill_valid !== 1'b0 || refill_err !== 1'b0 ||
            AXI_ARVALID !== 1'b0 || AXI_RREADY !== 1'b0 || AXI_ARADDR !== '0 ||
            refill_line !== '0) begin
            $display("FAIL reset_state: busy=%b rv=%b re=%b arvalid=%b rready=%b araddr=%h line=%h, expected all 0",
                     busy, refill_valid, refill_err, AXI_ARVALID, AXI_RREADY, AXI_ARADDR, refill_line);
            bad++;
        end
        total++;
        if (AXI_ARLEN !== 8'd7 || AXI_ARSIZE !== 3'd2 || AXI_ARBURST !== 2'b01 ||
            AXI_ARPROT !== 3'b100 || AXI_ARCACHE !== 4'b0110) begin
            $display("FAIL reset_consts: len=%h size=%h burst=%h prot=%h cache=%h, expected 07 2 1 4 6",
                     AXI_ARLEN, AXI_ARSIZE, AXI_ARBURST, AXI_ARPROT, AXI_ARCACHE);
            bad++;
        end
        AXI_RESETn = 1'b1;
        @(negedge AXI_CLK);
    endtask

    task automatic test_basic();
        run_refill("basic", 32'h0000_1234, 0, 0, -1, N_WORD - 1, -1, 1'b1);
    endtask

    task automatic test_ar_stall_gaps();
        run_refill("ar_stall", 32'h8000_5F7C, 5, 3, -1, N_WORD - 1, -1, 1'b0);
    endtask

    task automatic test_slverr();
        run_refill("slverr", 32'h0001_0040, 0, 0, 3, N_WORD - 1, -1, 1'b0);
    endtask

    task automatic test_rlast_errors();
        run_refill("rlast_early", 32'h0002_0000, 0, 0, -1, 4, -1, 1'b0);
        run_refill("rlast_missing", 32'h0002_0020, 0, 1, -1, -1, -1, 1'b0);
    endtask

    task automatic test_flush();
        @(negedge AXI_CLK);
        miss_req = 1'b1;
        flush    = 1'b1;
        miss_addr = 32'h0000_0100;
        @(negedge AXI_CLK);
        miss_req = 1'b0;
        flush    = 1'b0;
        total++;
        if (busy !== 1'b0 || AXI_ARVALID !== 1'b0) begin
            $display("FAIL flush_idle: busy=%b arvalid=%b expected 0 0", busy, AXI_ARVALID);
            bad++;
        end
        run_refill("flush_data", 32'h0003_0000, 0, 0, -1, N_WORD - 1, 2, 1'b0);
        run_refill("flush_resp", 32'h0003_0040, 1, 0, -1, N_WORD - 1, N_WORD, 1'b0);
        run_refill("after_flush", 32'h0003_0080, 0, 0, -1, N_WORD - 1, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            int bb;
            bb = int'($urandom_range(N_WORD + 3, 0));
            run_refill("random", $urandom, int'($urandom_range(3, 0)), int'($urandom_range(2, 0)),
                       (bb < N_WORD) ? bb : -1, N_WORD - 1, -1, 1'b0);
        end
    endtask

    task automatic test_reset_mid_burst();
        int pulses;
        pulses = 0;
        @(negedge AXI_CLK);
        miss_req  = 1'b1;
        miss_addr = 32'h0004_0000;
        @(negedge AXI_CLK);
        AXI_ARREADY = 1'b1;
        @(negedge AXI_CLK);
        AXI_ARREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            AXI_RVALID = 1'b1;
            AXI_RDATA  = $urandom;
            AXI_RRESP  = 2'b00;
            @(negedge AXI_CLK);
        end
        AXI_RDATA = $urandom;
        #2 AXI_RESETn = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || refill_valid !== 1'b0 || AXI_ARVALID !== 1'b0 ||
            AXI_RREADY !== 1'b0 || AXI_ARADDR !== '0 || refill_line !== '0) begin
            $display("FAIL reset_async: busy=%b rv=%b arvalid=%b rready=%b araddr=%h line=%h expected all 0",
                     busy, refill_valid, AXI_ARVALID, AXI_RREADY, AXI_ARADDR, refill_line);
            bad++;
        end
        model_clear();
        idle_inputs();
        @(negedge AXI_CLK);
        AXI_RESETn = 1'b1;
        repeat (12) begin
            @(negedge AXI_CLK);
            if (refill_valid !== 1'b0 || busy !== 1'b0) pulses++;
        end
        total++;
        if (pulses != 0) begin
            $display("FAIL reset_no_pulse: %0d active cycles after reset, expected 0", pulses);
            bad++;
        end
        // Early RLAST after reset: untouched words must read as cleared.
        run_refill("post_reset", 32'h0004_0020, 0, 0, -1, 1, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ar_stall_gaps();
        test_slverr();
        test_rlast_errors();
        test_flush();
        test_random();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
